// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl_unit: load-use/branch/MDU/memory-wait hazard control  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module hazard_ctrl_unit #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_ID,
  input  logic [REG_AW-1:0] rt_ID,
  input  logic              uses_rs_ID,
  input  logic              uses_rt_ID,
  input  logic              mdu_use_ID,
  input  logic [REG_AW-1:0] dest_EX,
  input  logic              MemRead_EX,
  input  logic              mdu_start_EX,
  input  logic              branch_taken_EX,
  input  logic              mem_req_MEM,
  input  logic              mem_ready,
  input  logic              cnt_clr,
  output logic              PC_write_enable,
  output logic              IF_ID_write_enable,
  output logic              IF_ID_flush,
  output logic              ID_EX_write_enable,
  output logic              ID_EX_flush,
  output logic              EX_MEM_write_enable,
  output logic              MEM_WB_flush,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int              MC_W     = $clog2(MDU_LAT + 1);
  localparam logic [MC_W-1:0] MDU_LOAD = MC_W'(MDU_LAT);
  localparam logic [MC_W-1:0] MC_ONE   = MC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [MC_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic lu;
  logic md;
  logic branch_flush;

  assign mdu_busy  = (state_q == S_BUSY);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    freeze = mem_req_MEM & ~mem_ready;
    lu     = MemRead_EX & (dest_EX != '0) &
             ((uses_rs_ID & (rs_ID == dest_EX)) | (uses_rt_ID & (rt_ID == dest_EX)));
    md     = mdu_use_ID & (mdu_busy | mdu_start_EX);
    branch_flush = 1'b0;

    PC_write_enable     = 1'b1;
    IF_ID_write_enable  = 1'b1;
    IF_ID_flush         = 1'b0;
    ID_EX_write_enable  = 1'b1;
    ID_EX_flush         = 1'b0;
    EX_MEM_write_enable = 1'b1;
    MEM_WB_flush        = 1'b0;

    // A pending branch under freeze is held in EX and re-presents once memory is ready.
    if (freeze) begin
      PC_write_enable     = 1'b0;
      IF_ID_write_enable  = 1'b0;
      ID_EX_write_enable  = 1'b0;
      EX_MEM_write_enable = 1'b0;
      MEM_WB_flush        = 1'b1;
    end else if (branch_taken_EX) begin
      branch_flush = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (lu | md) begin
      PC_write_enable    = 1'b0;
      IF_ID_write_enable = 1'b0;
      ID_EX_flush        = 1'b1;
    end
  end

  // The countdown keeps running through a freeze: the MDU itself is not stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mdu_start_EX & ~freeze) begin
          state_d = S_BUSY;
          cnt_d   = MDU_LOAD;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - MC_ONE;
        if (cnt_q == MC_ONE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (~PC_write_enable && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (branch_flush && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hazard_ctrl_unit: scoreboard bench for hazard_ctrl_unit        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_hazard_ctrl_unit;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  // {PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_we, MEM_WB_flush, mdu_busy}
  localparam logic [7:0] E_NORM    = 8'b1101_0100;
  localparam logic [7:0] E_NORM_B  = 8'b1101_0101;
  localparam logic [7:0] E_STALL   = 8'b0001_1100;
  localparam logic [7:0] E_STALL_B = 8'b0001_1101;
  localparam logic [7:0] E_BRANCH  = 8'b1111_1100;
  localparam logic [7:0] E_FREEZE  = 8'b0000_0010;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] rs_ID, rt_ID, dest_EX;
  logic              uses_rs_ID, uses_rt_ID, mdu_use_ID;
  logic              MemRead_EX, mdu_start_EX, branch_taken_EX;
  logic              mem_req_MEM, mem_ready, cnt_clr;
  logic              PC_write_enable, IF_ID_write_enable, IF_ID_flush;
  logic              ID_EX_write_enable, ID_EX_flush, EX_MEM_write_enable;
  logic              MEM_WB_flush, mdu_busy;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  wire [7:0] obs = {PC_write_enable, IF_ID_write_enable, IF_ID_flush, ID_EX_write_enable,
                    ID_EX_flush, EX_MEM_write_enable, MEM_WB_flush, mdu_busy};

  hazard_ctrl_unit #(
    .REG_AW (REG_AW),
    .MDU_LAT(MDU_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rs_ID              (rs_ID),
    .rt_ID              (rt_ID),
    .uses_rs_ID         (uses_rs_ID),
    .uses_rt_ID         (uses_rt_ID),
    .mdu_use_ID         (mdu_use_ID),
    .dest_EX            (dest_EX),
    .MemRead_EX         (MemRead_EX),
    .mdu_start_EX       (mdu_start_EX),
    .branch_taken_EX    (branch_taken_EX),
    .mem_req_MEM        (mem_req_MEM),
    .mem_ready          (mem_ready),
    .cnt_clr            (cnt_clr),
    .PC_write_enable    (PC_write_enable),
    .IF_ID_write_enable (IF_ID_write_enable),
    .IF_ID_flush        (IF_ID_flush),
    .ID_EX_write_enable (ID_EX_write_enable),
    .ID_EX_flush        (ID_EX_flush),
    .EX_MEM_write_enable(EX_MEM_write_enable),
    .MEM_WB_flush       (MEM_WB_flush),
    .mdu_busy           (mdu_busy),
    .stall_cnt          (stall_cnt),
    .flush_cnt          (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    rs_ID = '0; rt_ID = '0; dest_EX = '0;
    uses_rs_ID = 1'b0; uses_rt_ID = 1'b0; mdu_use_ID = 1'b0;
    MemRead_EX = 1'b0; mdu_start_EX = 1'b0; branch_taken_EX = 1'b0;
    mem_req_MEM = 1'b0; mem_ready = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic push_wait(input logic [7:0] e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    set_idle();
    cnt_clr = 1'b1;
    next_cyc();
    cnt_clr = 1'b0;
  endtask

  task automatic set_lu_rs();
    MemRead_EX = 1'b1; dest_EX = 5'd8; rs_ID = 5'd8; uses_rs_ID = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0;
    set_idle();
    mdu_start_EX = 1'b1;
    #2;
    exp_q.push_back(E_NORM);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_outputs obs=%b exp=%b", obs, e); end
    next_cyc();
    checks++;
    if (mdu_busy !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b stall=%0d flush=%0d exp=0/0/0", mdu_busy, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    next_cyc();
  endtask

  task automatic test_load_use();
    logic [7:0] e;
    clear_counters();
    set_lu_rs();
    push_wait(E_STALL);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL lu_rs obs=%b exp=%b", obs, e); end
    next_cyc();
    set_idle();
    MemRead_EX = 1'b1; dest_EX = 5'd17; rs_ID = 5'd3; rt_ID = 5'd17; uses_rs_ID = 1'b1; uses_rt_ID = 1'b1;
    push_wait(E_STALL);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL lu_rt obs=%b exp=%b", obs, e); end
    next_cyc();
    set_idle();
    checks++;
    if (stall_cnt !== 4'd2) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_no_hazard();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      set_lu_rs();
      if (i == 0) begin dest_EX = 5'd0; rs_ID = 5'd0; end
      if (i == 1) uses_rs_ID = 1'b0;
      if (i == 2) MemRead_EX = 1'b0;
      push_wait(E_NORM);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL no_hazard_%0d obs=%b exp=%b", i, obs, e); end
      next_cyc();
    end
    set_idle();
    checks++;
    if (stall_cnt !== 4'd2) begin failures++; $display("FAIL no_hazard_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_mdu();
    logic [7:0] e;
    clear_counters();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      mdu_use_ID   = 1'b1;
      mdu_start_EX = (i == 0);
      push_wait((i == 0) ? E_STALL : ((i < 5) ? E_STALL_B : E_NORM));
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL mdu_stall_c%0d obs=%b exp=%b", i, obs, e); end
      next_cyc();
    end
    set_idle();
    checks++;
    if (stall_cnt !== 4'd5) begin failures++; $display("FAIL mdu_stall_cnt got=%0d exp=5", stall_cnt); end
    for (int i = 0; i < 6; i++) begin
      set_idle();
      mdu_start_EX = (i == 0);
      push_wait((i == 0 || i == 5) ? E_NORM : E_NORM_B);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL mdu_busy_c%0d obs=%b exp=%b", i, obs, e); end
      next_cyc();
    end
    set_idle();
    checks++;
    if (stall_cnt !== 4'd5) begin failures++; $display("FAIL mdu_nouse_stall_cnt got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_branch();
    logic [7:0] e;
    clear_counters();
    set_lu_rs();
    branch_taken_EX = 1'b1;
    push_wait(E_BRANCH);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL branch_over_lu obs=%b exp=%b", obs, e); end
    next_cyc();
    set_idle();
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL branch_counts flush=%0d stall=%0d exp=1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_freeze();
    logic [7:0] e;
    clear_counters();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      branch_taken_EX = 1'b1;
      mem_req_MEM     = 1'b1;
      mem_ready       = (i == 3);
      push_wait((i < 3) ? E_FREEZE : E_BRANCH);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL freeze_c%0d obs=%b exp=%b", i, obs, e); end
      next_cyc();
    end
    set_idle();
    checks++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
      failures++;
      $display("FAIL freeze_counts stall=%0d flush=%0d exp=3/1", stall_cnt, flush_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      set_idle();
      mem_req_MEM  = (i == 0);
      mem_ready    = (i != 0);
      mdu_start_EX = (i == 0);
      push_wait((i == 0) ? E_FREEZE : E_NORM);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL freeze_mdu_c%0d obs=%b exp=%b", i, obs, e); end
      next_cyc();
    end
    set_idle();
  endtask

  task automatic test_reset_busy_and_saturation();
    logic [7:0] e;
    clear_counters();
    for (int i = 0; i < 3; i++) begin
      set_idle();
      mdu_use_ID   = 1'b1;
      mdu_start_EX = (i == 0);
      push_wait((i == 0) ? E_STALL : E_STALL_B);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL prereset_c%0d obs=%b exp=%b", i, obs, e); end
      next_cyc();
    end
    set_idle();
    checks++;
    if (mdu_busy !== 1'b1 || stall_cnt !== 4'd3) begin
      failures++;
      $display("FAIL prereset_state busy=%b stall=%0d exp=1/3", mdu_busy, stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mdu_busy !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      failures++;
      $display("FAIL async_reset busy=%b stall=%0d flush=%0d exp=0/0/0", mdu_busy, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    push_wait(E_NORM);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL postreset_idle obs=%b exp=%b", obs, e); end
    next_cyc();
    for (int i = 0; i < 17; i++) begin
      set_idle();
      set_lu_rs();
      push_wait(E_STALL);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sat_stall_c%0d obs=%b exp=%b", i, obs, e); end
      next_cyc();
    end
    for (int i = 0; i < 16; i++) begin
      set_idle();
      branch_taken_EX = 1'b1;
      push_wait(E_BRANCH);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sat_flush_c%0d obs=%b exp=%b", i, obs, e); end
      next_cyc();
    end
    set_idle();
    checks++;
    if (stall_cnt !== 4'd15 || flush_cnt !== 4'd15) begin
      failures++;
      $display("FAIL saturation stall=%0d flush=%0d exp=15/15", stall_cnt, flush_cnt);
    end
    set_lu_rs();
    cnt_clr = 1'b1;
    push_wait(E_STALL);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL clr_cycle obs=%b exp=%b", obs, e); end
    next_cyc();
    set_idle();
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      failures++;
      $display("FAIL cnt_clr stall=%0d flush=%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mdu();
    test_branch();
    test_freeze();
    test_reset_busy_and_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
